vmask_accum: RTL and testbench
==============================

VMASK_ACCUM -- requirements
Module: vmask_accum

Interface
REQ-001 Parameter DATA_WIDTH, 64, mask word width in bits.
REQ-002 Parameter ADDR_WIDTH, 32, register-file word address width.
REQ-003 Parameter BE_WIDTH, DATA_WIDTH/8, byte-enable width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  compare-result beat present.
REQ-008 in_ready  out  1  block accepts beat; a beat transfers when in_valid & in_ready.
REQ-009 in_addr  in  ADDR_WIDTH  destination mask-register word address; sampled only on a group's first beat.
REQ-010 in_mask  in  8  per-element compare bits, bit 0 = lowest element.
REQ-011 in_cnt  in  4  number of valid bits in in_mask, 0..8.
REQ-012 in_last  in  1  beat is the final beat of the vector (group end).
REQ-013 out_valid  out  1  packed mask word present.
REQ-014 out_ready  in  1  downstream writeback accepts word.
REQ-015 out_addr  out  ADDR_WIDTH  word write address.
REQ-016 out_vec  out  DATA_WIDTH  packed mask word.
REQ-017 out_be  out  BE_WIDTH  byte enables for out_vec.

Function
REQ-018 States: IDLE (no group open), ACCUM (group open, collecting), HOLD (word presented, awaiting out_ready).
REQ-019 in_ready SHALL be 1 in IDLE and ACCUM, 0 in HOLD and while rst is high.
REQ-020 Accepted beat in IDLE: latch base address = in_addr, word index = 0, fill_ptr = 0, then pack; go to ACCUM unless an emit condition holds.
REQ-021 Packing: for i < in_cnt, accumulator bit (fill_ptr + i) = in_mask[i]; fill_ptr += in_cnt; bits of in_mask at or above in_cnt ignored.
REQ-022 in_cnt SHALL be in {0,1,2,4,8} and constant within a group; bits that would land at position >= 64 SHALL be dropped and fill_ptr saturates at 64.
REQ-023 Emit condition: after packing, fill_ptr == 64, or in_last accepted with fill_ptr > 0.
REQ-024 On emit: next cycle out_valid = 1, out_vec = accumulator with all bits >= fill_ptr forced to 0, out_be[k] = 1 iff 8k < fill_ptr, out_addr = base + word index; state -> HOLD; latency one cycle from completing beat.
REQ-025 out_vec/out_addr/out_be SHALL remain stable while out_valid & !out_ready.
REQ-026 HOLD with out_ready: out_valid -> 0 next cycle, accumulator and fill_ptr cleared, word index += 1; next state IDLE if the emitted word ended the group, else ACCUM.
REQ-027 in_last accepted with fill_ptr == 0 (all prior bits already emitted or only in_cnt = 0 beats): no word emitted; state -> IDLE.
REQ-028 in_cnt = 0 beat without in_last: no state change except IDLE -> ACCUM with address latch.
REQ-029 Word index SHALL wrap modulo 2^ADDR_WIDTH when added to base.

Reset
REQ-030 rst SHALL force state IDLE, fill_ptr 0, word index 0, accumulator 0, out_valid 0, out_vec 0, out_be 0, out_addr 0, in_ready 0 during reset.
REQ-031 rst asserted mid-group or in HOLD SHALL discard the partial or pending word with no output.

Structure
REQ-032 Shared package vmask_pkg SHALL hold DATA_WIDTH/ADDR_WIDTH defaults and the state enum (IDLE, ACCUM, HOLD).
REQ-033 One combinational sub-module vmask_insert SHALL perform REQ-021 bit insertion (accumulator, fill_ptr, in_mask, in_cnt -> new accumulator, new fill_ptr).

Verification
REQ-034 8 beats in_cnt=8, in_mask=0xA5, in_last on 8th, in_addr=0x10 -> one word out_vec=0xA5A5A5A5A5A5A5A5, out_be=0xFF, out_addr=0x10, one cycle after 8th beat.
REQ-035 3 beats in_cnt=2, in_mask=0b11,0b01,0b10, last on 3rd -> out_vec=0x27, out_be=0x01.
REQ-036 16 beats in_cnt=8 mask 0xFF, out_ready=0 for 5 cycles after first word -> in_ready=0 during HOLD, word 1 addr base, word 2 addr base+1, outputs stable while stalled.
REQ-037 8 beats in_cnt=8 then extra beat in_cnt=0 with in_last -> exactly one word emitted, state returns IDLE.
REQ-038 rst asserted after 4 beats in_cnt=8 -> no out_valid; next group with in_addr=0x20 emits out_addr=0x20 with only new bits.

Source files
------------

// File: rtl/vmask_pkg.sv
// Shared defaults and state encoding for the vector-mask accumulator.
package vmask_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 64;
  localparam int unsigned ADDR_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

endpackage

// File: rtl/vmask_insert.sv
// Combinational insertion of up to eight compare bits at the current fill pointer.
module vmask_insert #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned FILL_W     = $clog2(DATA_WIDTH) + 1
) (
  input  logic [DATA_WIDTH-1:0] acc_i,
  input  logic [FILL_W-1:0]     fill_i,
  input  logic [7:0]            mask_i,
  input  logic [3:0]            cnt_i,
  output logic [DATA_WIDTH-1:0] acc_o,
  output logic [FILL_W-1:0]     fill_o
);

  logic [FILL_W:0] sum;

  always_comb begin
    acc_o = acc_i;
    sum   = {1'b0, fill_i} + (FILL_W+1)'(cnt_i);
    // Positions past the word end never match, so overflow bits are dropped.
    for (int j = 0; j < DATA_WIDTH; j++) begin
      if ((j >= int'(fill_i)) && (j < int'(sum))) begin
        acc_o[j] = mask_i[3'(j - int'(fill_i))];
      end
    end
    fill_o = (sum > (FILL_W+1)'(DATA_WIDTH)) ? FILL_W'(DATA_WIDTH) : sum[FILL_W-1:0];
  end

endmodule

// File: rtl/vmask_accum.sv
// Packs per-element compare beats into mask words and emits them with byte enables.
module vmask_accum
  import vmask_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [7:0]            in_mask,
  input  logic [3:0]            in_cnt,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_vec,
  output logic [BE_WIDTH-1:0]   out_be
);

  localparam int unsigned FillW = $clog2(DATA_WIDTH) + 1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [FillW-1:0]      fill_q, fill_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  grp_end_q, grp_end_d;
  logic                  ov_q, ov_d;
  logic [DATA_WIDTH-1:0] ovec_q, ovec_d;
  logic [BE_WIDTH-1:0]   obe_q, obe_d;
  logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;

  logic [DATA_WIDTH-1:0] ins_acc, new_acc, keep;
  logic [FillW-1:0]      ins_fill, new_fill;
  logic [ADDR_WIDTH-1:0] cur_base, cur_idx;
  logic [BE_WIDTH-1:0]   be;
  logic                  in_fire, emit;

  assign in_ready  = !rst && (state_q != StHold);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = ov_q;
  assign out_vec   = ovec_q;
  assign out_be    = obe_q;
  assign out_addr  = oaddr_q;

  // A group's first beat packs into a fresh word regardless of leftover state.
  assign ins_acc  = (state_q == StIdle) ? '0 : acc_q;
  assign ins_fill = (state_q == StIdle) ? '0 : fill_q;
  assign cur_base = (state_q == StIdle) ? in_addr : base_q;
  assign cur_idx  = (state_q == StIdle) ? '0 : idx_q;

  vmask_insert #(
    .DATA_WIDTH (DATA_WIDTH),
    .FILL_W     (FillW)
  ) u_insert (
    .acc_i  (ins_acc),
    .fill_i (ins_fill),
    .mask_i (in_mask),
    .cnt_i  (in_cnt),
    .acc_o  (new_acc),
    .fill_o (new_fill)
  );

  assign emit = (new_fill == FillW'(DATA_WIDTH)) || (in_last && (new_fill != '0));

  always_comb begin
    keep = '0;
    be   = '0;
    for (int j = 0; j < DATA_WIDTH; j++) keep[j] = (j < int'(new_fill));
    for (int k = 0; k < BE_WIDTH; k++) be[k] = ((8 * k) < int'(new_fill));
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fill_d    = fill_q;
    base_d    = base_q;
    idx_d     = idx_q;
    grp_end_d = grp_end_q;
    ov_d      = ov_q;
    ovec_d    = ovec_q;
    obe_d     = obe_q;
    oaddr_d   = oaddr_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (in_fire) begin
          base_d = cur_base;
          idx_d  = cur_idx;
          if (emit) begin
            acc_d     = new_acc;
            fill_d    = new_fill;
            ov_d      = 1'b1;
            ovec_d    = new_acc & keep;
            obe_d     = be;
            oaddr_d   = cur_base + cur_idx;
            grp_end_d = in_last;
            state_d   = StHold;
          end else if (in_last) begin
            acc_d   = '0;
            fill_d  = '0;
            state_d = StIdle;
          end else begin
            acc_d   = new_acc;
            fill_d  = new_fill;
            state_d = StAccum;
          end
        end
      end
      StHold: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          acc_d   = '0;
          fill_d  = '0;
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = grp_end_q ? StIdle : StAccum;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      fill_q    <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      grp_end_q <= 1'b0;
      ov_q      <= 1'b0;
      ovec_q    <= '0;
      obe_q     <= '0;
      oaddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      grp_end_q <= grp_end_d;
      ov_q      <= ov_d;
      ovec_q    <= ovec_d;
      obe_q     <= obe_d;
      oaddr_q   <= oaddr_d;
    end
  end

endmodule

// File: tb/tb_vmask_accum.sv
// Directed bench for vmask_accum with hand-computed expected words.
module tb_vmask_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [7:0]  in_mask;
  logic [3:0]  in_cnt;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [63:0] out_vec;
  logic [7:0]  out_be;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vmask_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_mask   (in_mask),
    .in_cnt    (in_cnt),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_vec   (out_vec),
    .out_be    (out_be)
  );

  // Presents one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [31:0] a, input logic [7:0] m, input logic [3:0] c,
                           input logic l);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    in_mask  = m;
    in_cnt   = c;
    in_last  = l;
    for (int t = 0; t < 20; t++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL beat_accept: in_ready never 1 (got %0b, need 1)", acc);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_out_valid: got %0b need 0", out_valid);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_in_ready: got %0b need 0", in_ready);
    end
    n_vec++;
    if ((out_vec !== 64'h0) || (out_be !== 8'h0) || (out_addr !== 32'h0)) begin
      n_err++;
      $display("FAIL rst_outputs: vec %h be %h addr %h need zeros", out_vec, out_be, out_addr);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL post_rst_in_ready: got %0b need 1", in_ready);
    end
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      // Address is only sampled on the first beat; later beats carry junk.
      send_beat((i == 0) ? 32'h10 : 32'hDEAD_0000, 8'hA5, 4'd8, i == 7);
      if (i < 7) begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL full_early_valid beat %0d: got %0b need 0", i, out_valid);
        end
      end
    end
    n_vec++;
    if ((out_valid !== 1'b1) || (out_vec !== 64'hA5A5_A5A5_A5A5_A5A5)) begin
      n_err++;
      $display("FAIL full_word: valid %0b vec %h need 1 a5a5a5a5a5a5a5a5", out_valid, out_vec);
    end
    n_vec++;
    if ((out_be !== 8'hFF) || (out_addr !== 32'h10)) begin
      n_err++; $display("FAIL full_be_addr: be %h addr %h need ff 00000010", out_be, out_addr);
    end
    tick();
    n_vec++;
    if ((out_valid !== 1'b0) || (in_ready !== 1'b1)) begin
      n_err++;
      $display("FAIL full_release: valid %0b ready %0b need 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_partial();
    out_ready = 1'b1;
    send_beat(32'h30, 8'b11, 4'd2, 1'b0);
    send_beat(32'h0, 8'b01, 4'd2, 1'b0);
    send_beat(32'h0, 8'b10, 4'd2, 1'b1);
    n_vec++;
    if ((out_valid !== 1'b1) || (out_vec !== 64'h27) || (out_be !== 8'h01)) begin
      n_err++;
      $display("FAIL partial_word: valid %0b vec %h be %h need 1 27 01", out_valid, out_vec,
               out_be);
    end
    n_vec++;
    if (out_addr !== 32'h30) begin
      n_err++; $display("FAIL partial_addr: got %h need 00000030", out_addr);
    end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_beat(32'h40, 8'hFF, 4'd8, 1'b0);
    n_vec++;
    if ((out_valid !== 1'b1) || (out_vec !== 64'hFFFF_FFFF_FFFF_FFFF) || (out_addr !== 32'h40))
    begin
      n_err++;
      $display("FAIL stall_word1: valid %0b vec %h addr %h need 1 ffffffffffffffff 00000040",
               out_valid, out_vec, out_addr);
    end
    for (int c = 0; c < 5; c++) begin
      n_vec++;
      if ((in_ready !== 1'b0) || (out_valid !== 1'b1) || (out_vec !== 64'hFFFF_FFFF_FFFF_FFFF)
          || (out_addr !== 32'h40) || (out_be !== 8'hFF)) begin
        n_err++;
        $display("FAIL stall_hold cyc %0d: ready %0b valid %0b vec %h addr %h be %h", c,
                 in_ready, out_valid, out_vec, out_addr, out_be);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    n_vec++;
    if ((out_valid !== 1'b0) || (in_ready !== 1'b1)) begin
      n_err++;
      $display("FAIL stall_release: valid %0b ready %0b need 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < 8; i++) send_beat(32'h9999, 8'hFF, 4'd8, i == 7);
    n_vec++;
    if ((out_valid !== 1'b1) || (out_addr !== 32'h41) || (out_be !== 8'hFF)) begin
      n_err++;
      $display("FAIL stall_word2: valid %0b addr %h be %h need 1 00000041 ff", out_valid,
               out_addr, out_be);
    end
    tick();
  endtask

  task automatic test_zero_last();
    int words;
    out_ready = 1'b1;
    words = 0;
    for (int i = 0; i < 8; i++) begin
      send_beat(32'h50, 8'h3C, 4'd8, 1'b0);
      if (out_valid) words++;
    end
    tick();
    send_beat(32'h0, 8'hFF, 4'd0, 1'b1);
    if (out_valid) words++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (out_valid) words++;
    end
    n_vec++;
    if (words != 1) begin
      n_err++; $display("FAIL zero_last_words: got %0d need 1", words);
    end
    // A fresh group landing at its own address shows the block went back to idle.
    send_beat(32'h60, 8'h81, 4'd8, 1'b1);
    n_vec++;
    if ((out_valid !== 1'b1) || (out_addr !== 32'h60) || (out_vec !== 64'h81)
        || (out_be !== 8'h01)) begin
      n_err++;
      $display("FAIL zero_last_idle: valid %0b addr %h vec %h be %h need 1 00000060 81 01",
               out_valid, out_addr, out_vec, out_be);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(32'h70, 8'hFF, 4'd8, 1'b0);
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_ready: got %0b need 0", in_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_valid: got %0b need 0", out_valid);
    end
    send_beat(32'h20, 8'h05, 4'd4, 1'b0);
    send_beat(32'h0, 8'h0A, 4'd4, 1'b1);
    n_vec++;
    if ((out_valid !== 1'b1) || (out_addr !== 32'h20) || (out_vec !== 64'hA5)
        || (out_be !== 8'h01)) begin
      n_err++;
      $display("FAIL rst_mid_group: valid %0b addr %h vec %h be %h need 1 00000020 a5 01",
               out_valid, out_addr, out_vec, out_be);
    end
    tick();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(32'hFFFF_FFFF, 8'h01, 4'd8, 1'b0);
    n_vec++;
    if ((out_addr !== 32'hFFFF_FFFF) || (out_vec !== 64'h0101_0101_0101_0101)) begin
      n_err++;
      $display("FAIL wrap_word1: addr %h vec %h need ffffffff 0101010101010101", out_addr,
               out_vec);
    end
    tick();
    for (int i = 0; i < 8; i++) send_beat(32'h0, 8'h01, 4'd8, i == 7);
    n_vec++;
    if ((out_valid !== 1'b1) || (out_addr !== 32'h0)) begin
      n_err++; $display("FAIL wrap_word2: valid %0b addr %h need 1 00000000", out_valid, out_addr);
    end
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_mask   = '0;
    in_cnt    = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_full_word();
    test_partial();
    test_stall();
    test_zero_last();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
